sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 sin  input  1  serial data bit from the upstream parallel-to-serial stage.
REQ-005 sin_valid  input  1  high when sin carries a valid bit this cycle.
REQ-006 dout  output  WIDTH  assembled parallel word.
REQ-007 dout_valid  output  1  dout holds an unconsumed word.
REQ-008 dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 overrun  output  1  one-cycle pulse: a completed word was dropped.

Function
REQ-010 Sampling: sin SHALL be shifted in only on rising clk with sin_valid=1; with sin_valid=0 the shift register and bit counter hold.
REQ-011 Bit order: first received bit SHALL land in dout[WIDTH-1] (MSB first); last bit in dout[0].
REQ-012 Shift-side FSM states: IDLE (count 0), SHIFT (1..WIDTH-1 bits held), PARITY (only with macro; data complete, awaiting parity bit).
REQ-013 Transitions: IDLE->SHIFT on first valid bit; SHIFT->IDLE on bit WIDTH (->PARITY with macro); PARITY->IDLE on next valid bit.
REQ-014 Counter width clog2(WIDTH+1); it SHALL reset to 0 on word completion, never wrap past WIDTH.
REQ-015 Completion: on the edge sampling the final bit, the word SHALL load into the output register; dout_valid high from the following cycle (latency 1 after last bit).
REQ-016 Handshake: transfer occurs when dout_valid=1 and dout_ready=1; dout_valid clears next cycle unless a new word loads that same edge.
REQ-017 dout SHALL be stable while dout_valid=1 and not yet transferred.
REQ-018 Shifting of the next word SHALL continue while the output register is occupied.
REQ-019 Completion while dout_valid=1 and no transfer that edge: new word dropped, dout unchanged, overrun high for exactly one cycle.
REQ-020 Completion coinciding with transfer: new word loads, dout_valid remains 1, no overrun.
REQ-021 dout_ready while dout_valid=0 SHALL have no effect.

Reset
REQ-022 rst=1 SHALL force dout=0, dout_valid=0, overrun=0, counter=0, FSM=IDLE; partial word discarded.
REQ-023 rst SHALL override every simultaneous event, including completion and transfer.
REQ-024 First valid bit after rst deasserts SHALL be treated as the MSB of a new word.

Configuration
REQ-025 Macro SIPO_DESER_PARITY_EN defined: one extra serial bit follows each word; even parity over data+parity bit; output parity_err (1 bit) registered with the word, valid alongside dout_valid; word delivered regardless; reset value 0.
REQ-026 Macro undefined: no PARITY state, no parity_err port; words complete after WIDTH bits.

Structure
REQ-027 Package sipo_deser_pkg SHALL hold the FSM state enum and the WIDTH default constant.
REQ-028 One sub-module, sipo_out_reg: output holding register with valid/ready handshake and overrun pulse generation.

Verification (WIDTH=4, macro undefined unless stated)
REQ-029 rst=1 two cycles, after two bits already shifted -> dout=0000, dout_valid=0, overrun=0; then bits 0,0,1,1 -> dout=0011.
REQ-030 Bits 1,1,0,1 back-to-back, dout_ready=1 -> dout=1101, dout_valid high one cycle after 4th bit, low the cycle after.
REQ-031 Bits 1,0, sin_valid low 3 cycles, then 1,0 -> dout=1010, single dout_valid.
REQ-032 dout_ready=0, words 1101 then 0110 -> overrun one-cycle pulse at second completion, dout stays 1101; then dout_ready=1 -> transfer, dout_valid=0.
REQ-033 dout_ready=1 exactly on the edge completing 0110 while 1101 pending -> dout=0110, dout_valid stays 1, overrun=0.
REQ-034 Macro defined: bits 1,1,0,1 + parity 0 -> parity_err=1; 1,1,0,1 + parity 1 -> parity_err=0; both words delivered.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
// Optional macro SIPO_DESER_PARITY_EN adds a trailing even-parity bit per word.
package sipo_deser_pkg;

    // Default parallel word width.
    localparam int WIDTH_DEFAULT = 4;

    // Shift-side states. ST_PARITY is reachable only with SIPO_DESER_PARITY_EN.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register for the deserializer: valid/ready handshake,
// load of completed words, and a one-cycle overrun pulse when a completed
// word finds the register occupied and not draining.
module sipo_out_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_overrun
);

    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          w_xfer;
    logic          w_accept;

    // A ready with nothing held is ignored; a load is accepted when the
    // register is empty or is being drained on the same edge.
    assign w_xfer   = r_valid && i_ready;
    assign w_accept = i_load && (!r_valid || i_ready);

    // Hold register update: load, drain, or flag a dropped word.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples the
        // pre-edge values; blocking here would create order-dependent logic.
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && r_valid && !i_ready;
            if (w_accept) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer, MSB first, with a one-word output buffer.
// Define SIPO_DESER_PARITY_EN to expect one even-parity bit after each word
// and report parity_err alongside the delivered word.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SIPO_DESER_PARITY_EN
    // Whole word is held in the shifter while waiting for the parity bit.
    localparam int SR_W = WIDTH;
    localparam int DW   = WIDTH + 1;
`else
    // The final bit goes straight to the output register, so only
    // WIDTH-1 bits need storing here.
    localparam int SR_W = WIDTH - 1;
    localparam int DW   = WIDTH;
`endif

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0] r_shift;
    logic [SR_W:0]   w_next;
    logic            w_done;
    logic [DW-1:0]   w_load_data;
    logic [DW-1:0]   w_out_data;

    assign w_next = {r_shift, sin};

`ifdef SIPO_DESER_PARITY_EN
    // Word completes when the parity bit arrives; error if data+parity is odd.
    assign w_done      = sin_valid && (r_state == ST_PARITY);
    assign w_load_data = {^w_next, r_shift};
`else
    // Word completes on the edge that samples its last data bit.
    assign w_done      = sin_valid && (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
    assign w_load_data = w_next;
`endif

    // Shift-side FSM, bit counter and shift register; everything holds
    // while sin_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (sin_valid) begin
            case (r_state)
                ST_IDLE: begin
                    r_shift <= w_next[SR_W-1:0];
                    r_cnt   <= CNT_W'(1);
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_shift <= w_next[SR_W-1:0];
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
`ifdef SIPO_DESER_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_IDLE;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    sipo_out_reg #(
        .DW(DW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_done),
        .i_data   (w_load_data),
        .i_ready  (dout_ready),
        .o_data   (w_out_data),
        .o_valid  (dout_valid),
        .o_overrun(overrun)
    );

    assign dout = w_out_data[WIDTH-1:0];
`ifdef SIPO_DESER_PARITY_EN
    assign parity_err = w_out_data[WIDTH];
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser at WIDTH=4. Without SIPO_DESER_PARITY_EN
// it exercises reset, framing, stalls, overrun and transfer/complete overlap;
// with the macro it exercises the parity-bit path.
module tb_sipo_deser;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
`ifdef SIPO_DESER_PARITY_EN
    logic         parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sipo_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overrun   (overrun)
`ifdef SIPO_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic tick(input logic s, input logic v, input logic r);
        sin        = s;
        sin_valid  = v;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check dout, dout_valid and overrun together.
    task automatic check_out(input string tag, input logic [W-1:0] e_dout,
                             input logic e_valid, input logic e_ovr);
        check({tag, ".dout"}, 32'(dout), 32'(e_dout));
        check({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
        check({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
    endtask

    initial begin
        rst        = 1'b1;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        dout_ready = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_out("reset", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

`ifdef SIPO_DESER_PARITY_EN
        // 1101 + parity 0: four ones... data has three ones, so odd -> error.
        tick(1, 1, 1); tick(1, 1, 1); tick(0, 1, 1); tick(1, 1, 1);
        check("par_wait.valid", 32'(dout_valid), 32'(0));
        tick(0, 1, 0);
        check_out("par0", 4'b1101, 1'b1, 1'b0);
        check("par0.err", 32'(parity_err), 32'(1));
        tick(0, 0, 1);
        check("par0_xfer.valid", 32'(dout_valid), 32'(0));
        // 1101 + parity 1: even total -> no error.
        tick(1, 1, 0); tick(1, 1, 0); tick(0, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
        check_out("par1", 4'b1101, 1'b1, 1'b0);
        check("par1.err", 32'(parity_err), 32'(0));
        tick(0, 0, 1);
        check("par1_xfer.valid", 32'(dout_valid), 32'(0));
`else
        // Partial word then reset held two cycles with valid bits present.
        tick(1, 1, 0); tick(0, 1, 0);
        rst = 1'b1;
        tick(1, 1, 1); tick(1, 1, 1);
        check_out("rst_mid", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick(0, 1, 0); tick(0, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
        check_out("after_rst", 4'b0011, 1'b1, 1'b0);
        tick(0, 0, 1);
        check("after_rst_xfer.valid", 32'(dout_valid), 32'(0));

        // Back-to-back 1101 with ready held high.
        tick(1, 1, 1); tick(1, 1, 1); tick(0, 1, 1);
        check("b2b_3bits.valid", 32'(dout_valid), 32'(0));
        tick(1, 1, 1);
        check_out("b2b", 4'b1101, 1'b1, 1'b0);
        tick(0, 0, 1);
        check("b2b_drop.valid", 32'(dout_valid), 32'(0));

        // 1,0 then three idle cycles then 1,0.
        tick(1, 1, 0); tick(0, 1, 0);
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
        check("stall.valid", 32'(dout_valid), 32'(0));
        tick(1, 1, 0); tick(0, 1, 0);
        check_out("stall", 4'b1010, 1'b1, 1'b0);
        tick(0, 0, 0);
        check_out("stall_hold", 4'b1010, 1'b1, 1'b0);
        tick(0, 0, 1);
        check("stall_xfer.valid", 32'(dout_valid), 32'(0));

        // Overrun: 1101 pending, 0110 completes without ready.
        tick(1, 1, 0); tick(1, 1, 0); tick(0, 1, 0); tick(1, 1, 0);
        check_out("ovr_first", 4'b1101, 1'b1, 1'b0);
        tick(0, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
        check_out("ovr_shifting", 4'b1101, 1'b1, 1'b0);
        tick(0, 1, 0);
        check_out("ovr_pulse", 4'b1101, 1'b1, 1'b1);
        tick(0, 0, 0);
        check_out("ovr_after", 4'b1101, 1'b1, 1'b0);
        tick(0, 0, 1);
        check("ovr_xfer.valid", 32'(dout_valid), 32'(0));

        // Ready exactly on the edge completing 0110 while 1101 is pending.
        tick(1, 1, 0); tick(1, 1, 0); tick(0, 1, 0); tick(1, 1, 0);
        tick(0, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
        tick(0, 1, 1);
        check_out("xfer_load", 4'b0110, 1'b1, 1'b0);
        tick(0, 0, 1);
        check("xfer_load_drain.valid", 32'(dout_valid), 32'(0));

        // Reset wins over a simultaneous completion and transfer.
        tick(0, 1, 0); tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
        check_out("pre_rst", 4'b0111, 1'b1, 1'b0);
        tick(1, 1, 0); tick(0, 1, 0); tick(0, 1, 0);
        rst = 1'b1;
        tick(1, 1, 1);
        check_out("rst_override", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1, 1, 0); tick(0, 1, 0); tick(0, 1, 0); tick(0, 1, 0);
        check_out("post_rst_msb", 4'b1000, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
